// File: rtl/axis_frame_arbiter.sv
// rtl/axis_frame_arbiter.sv - frame-atomic round-robin AXI-Stream arbiter with inter-frame gap
// A grant is held from a frame's first beat until its tlast handshake, then IFG_CYCLES idle cycles follow.
module axis_frame_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 8,
    parameter int IFG_CYCLES = 0,
    localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]          s_axis_tvalid,
    output logic [NUM_PORTS-1:0]          s_axis_tready,
    input  logic [NUM_PORTS-1:0]          s_axis_tlast,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [IW-1:0]                 grant_index,
    output logic                          busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_PASS, ST_GAP} state_t;

    state_t          state_q;
    logic [IW-1:0]   sel_q;
    logic [IW-1:0]   last_grant_q;
    logic [7:0]      gap_q;

    logic [IW-1:0]   win;
    logic            any_valid;
    logic            pass;
    logic            last_beat;

    // Search upward from the port after the last winner, wrapping modulo NUM_PORTS.
    always_comb begin
        int idx;
        win       = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = int'(last_grant_q) + k;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (!any_valid && s_axis_tvalid[idx]) begin
                any_valid = 1'b1;
                win       = IW'(idx);
            end
        end
    end

    assign pass      = (state_q == ST_PASS);
    assign last_beat = m_axis_tvalid & m_axis_tready & m_axis_tlast;

    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        if (pass) begin
            m_axis_tdata         = s_axis_tdata[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];
            m_axis_tvalid        = s_axis_tvalid[sel_q];
            m_axis_tlast         = s_axis_tlast[sel_q];
            s_axis_tready[sel_q] = m_axis_tready;
        end
    end

    assign grant_index = sel_q;
    assign busy        = (state_q != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            last_grant_q <= IW'(NUM_PORTS - 1);
            gap_q        <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_valid) begin
                        sel_q        <= win;
                        last_grant_q <= win;
                        state_q      <= ST_PASS;
                    end
                end
                ST_PASS: begin
                    if (last_beat) state_q <= (IFG_CYCLES > 0) ? ST_GAP : ST_IDLE;
                end
                ST_GAP: begin
                    if (gap_q == 8'(IFG_CYCLES - 1)) begin
                        gap_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        gap_q <= gap_q + 8'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// tb/tb_axis_frame_arbiter.sv - directed bench for axis_frame_arbiter (IFG 0 and IFG 3 instances)
module tb_axis_frame_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic [31:0] s_tdata;
    logic [3:0]  s_tvalid, s_tlast;
    logic        m_rdy;

    logic [3:0] o0_rdy, o3_rdy;
    logic [7:0] o0_data, o3_data;
    logic       o0_vld, o3_vld, o0_lst, o3_lst, o0_busy, o3_busy;
    logic [1:0] o0_gnt, o3_gnt;

    axis_frame_arbiter #(.NUM_PORTS(4), .DATA_WIDTH(8), .IFG_CYCLES(0)) dut0 (
        .clk(clk), .rstn(rstn),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(o0_rdy), .s_axis_tlast(s_tlast),
        .m_axis_tdata(o0_data), .m_axis_tvalid(o0_vld), .m_axis_tready(m_rdy), .m_axis_tlast(o0_lst),
        .grant_index(o0_gnt), .busy(o0_busy)
    );

    axis_frame_arbiter #(.NUM_PORTS(4), .DATA_WIDTH(8), .IFG_CYCLES(3)) dut3 (
        .clk(clk), .rstn(rstn),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(o3_rdy), .s_axis_tlast(s_tlast),
        .m_axis_tdata(o3_data), .m_axis_tvalid(o3_vld), .m_axis_tready(m_rdy), .m_axis_tlast(o3_lst),
        .grant_index(o3_gnt), .busy(o3_busy)
    );

    logic       use3;
    logic [3:0] c_rdy;
    logic [7:0] c_data;
    logic       c_vld, c_lst, c_busy;
    logic [1:0] c_gnt;
    assign c_rdy  = use3 ? o3_rdy  : o0_rdy;
    assign c_data = use3 ? o3_data : o0_data;
    assign c_vld  = use3 ? o3_vld  : o0_vld;
    assign c_lst  = use3 ? o3_lst  : o0_lst;
    assign c_busy = use3 ? o3_busy : o0_busy;
    assign c_gnt  = use3 ? o3_gnt  : o0_gnt;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  vld;
        logic [3:0]  lst;
        logic [31:0] dat;
        logic        mrdy;
        logic        e_vld;
        logic [7:0]  e_data;
        logic        e_lst;
        logic [3:0]  e_rdy;
        logic [1:0]  e_gnt;
        logic        e_busy;
    } vec_t;

    function automatic vec_t v(logic [3:0] vld, logic [3:0] lst, logic [31:0] dat, logic mrdy,
                               logic e_vld, logic [7:0] e_data, logic e_lst, logic [3:0] e_rdy,
                               logic [1:0] e_gnt, logic e_busy);
        vec_t r;
        r.vld = vld; r.lst = lst; r.dat = dat; r.mrdy = mrdy;
        r.e_vld = e_vld; r.e_data = e_data; r.e_lst = e_lst; r.e_rdy = e_rdy;
        r.e_gnt = e_gnt; r.e_busy = e_busy;
        return r;
    endfunction

    typedef struct {
        int         port;
        logic [7:0] data;
        logic       last;
        int         cyc;
    } beat_t;

    beat_t outq[$];
    int    len[4], beat[4], nfr[4];
    bit    tagmode, chk_rdy;
    int    rmode, cyc, rdy_err;
    bit    busy_hist[0:4095];

    task automatic drive();
        for (int p = 0; p < 4; p++) begin
            s_tvalid[p]        = nfr[p] > 0;
            s_tdata[p*8 +: 8]  = tagmode ? 8'(p) : 8'(beat[p]);
            s_tlast[p]         = (nfr[p] > 0) && (beat[p] == len[p] - 1);
        end
        m_rdy = (rmode == 0) ? 1'b1 : ((cyc % 20) < 10);
    endtask

    task automatic sample();
        beat_t b;
        busy_hist[cyc] = c_busy;
        if (c_vld && m_rdy) begin
            b.port = int'(c_gnt); b.data = c_data; b.last = c_lst; b.cyc = cyc;
            outq.push_back(b);
        end
        if (chk_rdy && (c_rdy !== (c_busy ? {m_rdy, 3'b000} : 4'b0000))) rdy_err++;
        for (int p = 0; p < 4; p++) begin
            if (s_tvalid[p] && c_rdy[p]) begin
                if (s_tlast[p]) begin
                    beat[p] = 0;
                    nfr[p]--;
                end else begin
                    beat[p]++;
                end
            end
        end
    endtask

    task automatic run(input int budget, input int stop_p, input int stop_b, input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            drive();
            @(negedge clk);
            sample();
            @(posedge clk);
            #1;
            cyc++;
            if (stop_p < 0) done = (nfr[0] + nfr[1] + nfr[2] + nfr[3]) == 0;
            else            done = beat[stop_p] == stop_b;
        end
        check({name, " completes"}, done, 1'b1);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        outq.delete();
        for (int p = 0; p < 4; p++) begin
            nfr[p] = 0; beat[p] = 0; len[p] = 1;
        end
        tagmode = 0; chk_rdy = 0; rmode = 0; cyc = 0; rdy_err = 0;
    endtask

    vec_t vt[18];

    initial begin
        int bad;
        int t;
        use3 = 1'b0;

        // reset state with requests pending
        rstn = 1'b0; s_tvalid = 4'b1111; s_tlast = 4'b1111; s_tdata = 32'hA5A5_A5A5; m_rdy = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("reset outputs", {o0_vld, o0_rdy, o0_gnt, o0_busy, o3_vld, o3_busy}, {1'b0, 4'b0, 2'd0, 1'b0, 1'b0, 1'b0});

        vt[0]  = v(4'b0011, 4'b0000, 32'h0000_1000, 1, 0, 8'h00, 0, 4'b0000, 0, 0);
        vt[1]  = v(4'b0011, 4'b0000, 32'h0000_1000, 0, 1, 8'h00, 0, 4'b0000, 0, 1);
        vt[2]  = v(4'b0011, 4'b0000, 32'h0000_1000, 1, 1, 8'h00, 0, 4'b0001, 0, 1);
        vt[3]  = v(4'b0011, 4'b0001, 32'h0000_1001, 1, 1, 8'h01, 1, 4'b0001, 0, 1);
        vt[4]  = v(4'b0010, 4'b0000, 32'h0000_1000, 1, 0, 8'h00, 0, 4'b0000, 0, 0);
        vt[5]  = v(4'b0010, 4'b0000, 32'h0000_1000, 1, 1, 8'h10, 0, 4'b0010, 1, 1);
        vt[6]  = v(4'b0010, 4'b0010, 32'h0000_1100, 1, 1, 8'h11, 1, 4'b0010, 1, 1);
        vt[7]  = v(4'b0001, 4'b0001, 32'h0000_0002, 1, 0, 8'h00, 0, 4'b0000, 1, 0);
        vt[8]  = v(4'b0001, 4'b0001, 32'h0000_0002, 1, 1, 8'h02, 1, 4'b0001, 0, 1);
        vt[9]  = v(4'b0000, 4'b0000, 32'h0000_0000, 1, 0, 8'h00, 0, 4'b0000, 0, 0);
        vt[10] = v(4'b1000, 4'b1000, 32'h3000_0000, 1, 0, 8'h00, 0, 4'b0000, 0, 0);
        vt[11] = v(4'b1000, 4'b1000, 32'h3000_0000, 0, 1, 8'h30, 1, 4'b0000, 3, 1);
        vt[12] = v(4'b1000, 4'b1000, 32'h3000_0000, 1, 1, 8'h30, 1, 4'b1000, 3, 1);
        vt[13] = v(4'b0110, 4'b0110, 32'h0020_1200, 1, 0, 8'h00, 0, 4'b0000, 3, 0);
        vt[14] = v(4'b0110, 4'b0110, 32'h0020_1200, 1, 1, 8'h12, 1, 4'b0010, 1, 1);
        vt[15] = v(4'b0100, 4'b0100, 32'h0020_0000, 1, 0, 8'h00, 0, 4'b0000, 1, 0);
        vt[16] = v(4'b0100, 4'b0100, 32'h0020_0000, 1, 1, 8'h20, 1, 4'b0100, 2, 1);
        vt[17] = v(4'b0000, 4'b0000, 32'h0000_0000, 1, 0, 8'h00, 0, 4'b0000, 2, 0);

        do_reset();
        for (int i = 0; i < 18; i++) begin
            s_tvalid = vt[i].vld; s_tlast = vt[i].lst; s_tdata = vt[i].dat; m_rdy = vt[i].mrdy;
            @(negedge clk);
            check($sformatf("vec%0d", i), {o0_vld, o0_data, o0_lst, o0_rdy, o0_gnt, o0_busy},
                  {vt[i].e_vld, vt[i].e_data, vt[i].e_lst, vt[i].e_rdy, vt[i].e_gnt, vt[i].e_busy});
            @(posedge clk); #1;
        end

        // single 64-byte frame from port 2
        do_reset();
        len[2] = 64; nfr[2] = 1;
        run(200, -1, 0, "single");
        check("single count", outq.size(), 64);
        check("single latency", outq.size() > 0 ? outq[0].cyc : -1, 1);
        bad = 0;
        foreach (outq[i]) if (outq[i].port != 2 || outq[i].data != 8'(i) || outq[i].last != (i == 63)) bad++;
        check("single payload", bad, 0);

        // contention: ports 0 and 1, 10-byte frames
        do_reset();
        len[0] = 10; nfr[0] = 1; len[1] = 10; nfr[1] = 1;
        run(100, -1, 0, "contention");
        check("contention count", outq.size(), 20);
        bad = 0;
        foreach (outq[i]) if (outq[i].port != i / 10 || outq[i].data != 8'(i % 10) || outq[i].last != (i % 10 == 9)) bad++;
        check("contention order", bad, 0);
        if (outq.size() == 20) check("contention gap", outq[10].cyc - outq[9].cyc, 2);

        // fairness: all ports, 2 frames of 4 tagged bytes each
        do_reset();
        tagmode = 1;
        for (int p = 0; p < 4; p++) begin len[p] = 4; nfr[p] = 2; end
        run(200, -1, 0, "fairness");
        check("fairness count", outq.size(), 32);
        bad = 0;
        foreach (outq[i]) if (outq[i].port != (i / 4) % 4 || outq[i].data != 8'((i / 4) % 4) || outq[i].last != (i % 4 == 3)) bad++;
        check("fairness order", bad, 0);

        // backpressure: port 3, 100 bytes, ready toggles every 10 cycles
        do_reset();
        rmode = 1; chk_rdy = 1;
        len[3] = 100; nfr[3] = 1;
        run(400, -1, 0, "backpressure");
        check("backpressure count", outq.size(), 100);
        bad = 0;
        foreach (outq[i]) if (outq[i].port != 3 || outq[i].data != 8'(i) || outq[i].last != (i == 99)) bad++;
        check("backpressure payload", bad, 0);
        check("backpressure tready mirror", rdy_err, 0);

        // inter-frame gap of 3 on the second instance
        use3 = 1'b1;
        do_reset();
        len[1] = 4; nfr[1] = 1; len[2] = 4; nfr[2] = 1;
        run(100, -1, 0, "gap");
        check("gap count", outq.size(), 8);
        if (outq.size() == 8) begin
            t = outq[3].cyc;
            check("gap ports", {outq[3].port[3:0], outq[3].last, outq[4].port[3:0]}, {4'd1, 1'b1, 4'd2});
            check("gap spacing", outq[4].cyc - t, 5);
            check("gap busy", {busy_hist[t+1], busy_hist[t+2], busy_hist[t+3], busy_hist[t+4]}, 4'b1110);
        end
        use3 = 1'b0;

        // reset in the middle of a frame from port 0
        do_reset();
        len[0] = 20; nfr[0] = 1; len[1] = 4; nfr[1] = 1;
        run(100, 0, 5, "midframe");
        rstn = 1'b0;
        drive();
        @(posedge clk); #1;
        @(negedge clk);
        check("midreset outputs", {o0_vld, o0_busy, o0_rdy, o0_gnt}, {1'b0, 1'b0, 4'b0, 2'd0});
        @(posedge clk); #1;
        beat[0] = 0; len[0] = 4; nfr[0] = 1;
        outq.delete(); cyc = 0;
        rstn = 1'b1;
        run(100, -1, 0, "postreset");
        check("postreset count", outq.size(), 8);
        if (outq.size() == 8)
            check("postreset grant", {outq[0].port[3:0], outq[0].data, outq[4].port[3:0]}, {4'd0, 8'h00, 4'd1});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_frame_arbiter.md
# axis_frame_arbiter

Frame-atomic round-robin arbiter that shares one AXI-Stream output among NUM_PORTS AXI-Stream input requesters. A grant is held from a frame's first beat until its tlast handshake, so frames are never interleaved. A programmable inter-frame gap is inserted between frames on the output. The block sits in front of the frame checker and TSN datapath stages and merges per-source frame streams onto a single byte-wide frame stream.

## Interface
Parameters:
- NUM_PORTS, 4: number of input streams; legal range 2..16.
- DATA_WIDTH, 8: tdata width of every stream.
- IFG_CYCLES, 0: idle cycles forced after each output tlast handshake, before arbitration resumes; legal range 0..255.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- s_axis_tdata  in  NUM_PORTS*DATA_WIDTH  port p occupies bits [p*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tvalid  in  NUM_PORTS  per-port valid.
- s_axis_tready  out  NUM_PORTS  per-port ready.
- s_axis_tlast  in  NUM_PORTS  per-port last beat of frame.
- m_axis_tdata  out  DATA_WIDTH  merged data.
- m_axis_tvalid  out  1  merged valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  merged last.
- grant_index  out  max(1,$clog2(NUM_PORTS))  currently or most recently granted port.
- busy  out  1  high while in PASS or GAP.

## Operation
- The arbiter has three states: IDLE, PASS and GAP.
- IDLE:
  - The block samples s_axis_tvalid. If no port is valid, it stays in IDLE.
  - Otherwise it selects the first valid port found searching upward from last_grant+1, wrapping modulo NUM_PORTS.
  - It registers the winner into sel and last_grant, then moves to PASS.
- PASS (combinational pass-through from port sel; zero added latency):
  - m_axis_tdata = s_axis_tdata[sel], m_axis_tvalid = s_axis_tvalid[sel], m_axis_tlast = s_axis_tlast[sel].
  - s_axis_tready[sel] = m_axis_tready. All other ready bits are 0.
  - On a beat where m_axis_tvalid & m_axis_tready & m_axis_tlast, the next state is GAP if IFG_CYCLES > 0, else IDLE.
- GAP:
  - gap_counter counts 0..IFG_CYCLES-1. On reaching IFG_CYCLES-1 it clears and the next state is IDLE.
  - All tready bits are 0 and m_axis_tvalid is 0.
- In IDLE and GAP:
  - m_axis_tvalid = 0 and all s_axis_tready = 0.
  - m_axis_tdata and m_axis_tlast are don't-care and are driven 0.
- grant_index = sel. busy = (state != IDLE).
- Requests that arrive during PASS or GAP are not lost; they are evaluated at the next IDLE cycle. Inputs must keep tvalid asserted until accepted, per AXI-Stream rules.
- A granted port that deasserts tvalid mid-frame keeps the grant; the arbiter waits indefinitely for its tlast. There is no timeout.

## Timing
- Reset values:
  - state = IDLE, sel = 0, last_grant = NUM_PORTS-1 (port 0 wins first), gap_counter = 0.
  - m_axis_tvalid = 0, s_axis_tready = 0, grant_index = 0, busy = 0.
- Arbitration latency: a request is seen in IDLE at cycle T. The first output beat can be presented at T+1 (PASS).
- Back-to-back frames: tlast handshake at cycle T. With IFG_CYCLES = 0, IDLE is at T+1 and the earliest next beat is at T+2 (1 idle cycle). With IFG_CYCLES = N, GAP spans T+1..T+N, IDLE is at T+N+1 and the earliest next beat is at T+N+2 (N+1 idle cycles).
- Backpressure: m_axis_tready low holds the granted source through its own tready. No beat is duplicated or dropped.
- Single-beat frame (tvalid and tlast on the first beat) is legal and costs one PASS cycle.
- Simultaneous requests: resolved only by round-robin order relative to last_grant, never by a fixed priority.
- Reset mid-frame: the next cycle is IDLE with all outputs at reset values. The partial frame is truncated without tlast; downstream recovery is not this block's responsibility.

## Test plan
- Single frame: port 2 sends a 64-byte frame (bytes 0x00..0x3F) with m_axis_tready = 1 -> output carries the identical 64 bytes with tlast on byte 0x3F; grant_index = 2; first output beat exactly 1 cycle after tvalid rises.
- Contention: ports 0 and 1 both assert tvalid in the first cycle after reset with 10-byte frames -> port 0's frame is output first, then port 1's. No interleaving. Exactly 1 idle output cycle between them (IFG_CYCLES = 0).
- Fairness: all 4 ports request continuously with 4-byte frames -> grant order 0,1,2,3,0,1,2,3 over 8 frames. Per-port payload tags (port number in every byte) match that order.
- Backpressure: m_axis_tready toggles with a 20-cycle period during a 100-byte frame from port 3 -> all 100 bytes are received in order. s_axis_tready[3] equals m_axis_tready every PASS cycle; other ready bits stay 0.
- Gap: IFG_CYCLES = 3, ports 1 and 2 pending -> exactly 4 cycles with m_axis_tvalid = 0 between port 1's tlast handshake and port 2's first beat; busy is high during the 3 GAP cycles.
- Reset mid-frame: rstn is pulled low on byte 5 of a 20-byte frame from port 0, then released while ports 0 and 1 are requesting -> m_axis_tvalid = 0 and busy = 0 during reset; after release the next grant goes to port 0 (last_grant reset to NUM_PORTS-1).
